// File: rtl/switch_allocator_pkg.sv
// Shared sizes, destination-code values, arbiter FSM states and the round-robin pick helper.
package switch_allocator_pkg;

   localparam int N_PORT     = 5;
   localparam int N_REGISTER = 3;

   localparam logic [N_REGISTER-1:0] DEST_NONE      = 3'd0;
   localparam logic [N_REGISTER-1:0] DEST_MAX_LEGAL = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_XFER    = 2'd1,
      ST_RECOVER = 2'd2
   } arb_state_e;

   // Returns {found, index}; the search starts just after ptr so the last winner ranks lowest.
   function automatic logic [N_REGISTER:0] rr_pick(input logic [N_PORT-1:0]     req,
                                                   input logic [N_REGISTER-1:0] ptr);
      logic [N_REGISTER:0] res;
      int idx;
      res = '0;
      for (int k = N_PORT; k >= 1; k--) begin
         idx = (int'(ptr) + k) % N_PORT;
         if (req[idx]) res = {1'b1, N_REGISTER'(idx)};
      end
      return res;
   endfunction

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// One output port's round-robin arbiter: pointer plus a 3-state transfer FSM.
//   state      | meaning
//   ST_IDLE    | waiting for a request while the downstream buffer has room
//   ST_XFER    | grant, valid and select driven for exactly one cycle
//   ST_RECOVER | quiet cycle so the input block can refresh its register
module switch_allocator_rr_arbiter
   import switch_allocator_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_PORT-1:0]     req_i,
   input  logic                  full_i,
   output logic [N_PORT-1:0]     grant_o,
   output logic                  val_o,
   output logic [N_REGISTER-1:0] sel_o
);

   arb_state_e            state_q, state_d;
   logic [N_REGISTER-1:0] ptr_q, ptr_d;
   logic [N_REGISTER-1:0] sel_q, sel_d;
   logic [N_PORT-1:0]     grant_q, grant_d;
   logic                  val_q, val_d;
   logic [N_REGISTER:0]   pick;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      grant_d = '0;
      val_d   = 1'b0;
      pick    = rr_pick(req_i, ptr_q);
      case (state_q)
         ST_IDLE: begin
            // Downstream fullness only matters here; once committed the flit goes.
            if (pick[N_REGISTER] && !full_i) begin
               state_d = ST_XFER;
               grant_d = N_PORT'(1) << pick[N_REGISTER-1:0];
               val_d   = 1'b1;
               sel_d   = pick[N_REGISTER-1:0];
               ptr_d   = pick[N_REGISTER-1:0];
            end
         end
         ST_XFER:    state_d = ST_RECOVER;
         ST_RECOVER: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= N_REGISTER'(N_PORT - 1);
         sel_q   <= '0;
         grant_q <= '0;
         val_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         grant_q <= grant_d;
         val_q   <= val_d;
      end
   end

   assign grant_o = grant_q;
   assign val_o   = val_q;
   assign sel_o   = sel_q;

endmodule

// File: rtl/switch_allocator.sv
// Switch allocator top: decodes destination codes, runs one arbiter per output, merges grants.
module switch_allocator
   import switch_allocator_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_PORT*N_REGISTER-1:0] req_dest,
   input  logic [N_PORT-1:0]            out_full,
   output logic [N_PORT-1:0]            grant,
   output logic [N_PORT*N_REGISTER-1:0] sel,
   output logic [N_PORT-1:0]            out_val,
   output logic                         dest_err
);

   logic [N_PORT-1:0][N_PORT-1:0] req_vec;
   logic [N_PORT-1:0][N_PORT-1:0] arb_grant;
   logic                          illegal;
   logic                          dest_err_q;

   always_comb begin
      req_vec = '0;
      illegal = 1'b0;
      for (int i = 0; i < N_PORT; i++) begin
         if (req_dest[i*N_REGISTER +: N_REGISTER] > DEST_MAX_LEGAL) illegal = 1'b1;
         for (int o = 0; o < N_PORT; o++) begin
            req_vec[o][i] = (req_dest[i*N_REGISTER +: N_REGISTER] == N_REGISTER'(o + 1));
         end
      end
   end

   for (genvar o = 0; o < N_PORT; o++) begin : g_arb
      switch_allocator_rr_arbiter u_arb (
         .clk    (clk),
         .rst    (rst),
         .req_i  (req_vec[o]),
         .full_i (out_full[o]),
         .grant_o(arb_grant[o]),
         .val_o  (out_val[o]),
         .sel_o  (sel[o*N_REGISTER +: N_REGISTER])
      );
   end

   // An input targets a single output, so at most one arbiter grants any given input.
   always_comb begin
      grant = '0;
      for (int o = 0; o < N_PORT; o++) grant = grant | arb_grant[o];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) dest_err_q <= 1'b0;
      else      dest_err_q <= dest_err_q | illegal;
   end

   assign dest_err = dest_err_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: expected transfers queued by stimulus, popped by a monitor.
module tb_switch_allocator;
   import switch_allocator_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [14:0] req_dest;
   logic [4:0]  out_full;
   logic [4:0]  grant;
   logic [14:0] sel;
   logic [4:0]  out_val;
   logic        dest_err;

   typedef struct packed {
      logic [4:0]  g;
      logic [4:0]  v;
      logic [14:0] s;
   } exp_t;

   exp_t        q[$];
   logic [14:0] exp_sel = '0;
   int          total  = 0;
   int          passed = 0;

   switch_allocator dut (
      .clk     (clk),
      .rst     (rst),
      .req_dest(req_dest),
      .out_full(out_full),
      .grant   (grant),
      .sel     (sel),
      .out_val (out_val),
      .dest_err(dest_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic set_code(input int i, input logic [2:0] c);
      req_dest[i*3 +: 3] = c;
   endtask

   task automatic push(input logic [4:0] g, input logic [4:0] v);
      q.push_back('{g: g, v: v, s: exp_sel});
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (rst === 1'b1 && (out_val !== 5'd0 || grant !== 5'd0)) begin
         if (q.size() == 0) begin
            chk("unexpected_xfer", {22'd0, grant, out_val}, 32'd0);
         end else begin
            e = q.pop_front();
            chk("grant", {27'd0, grant}, {27'd0, e.g});
            chk("out_val", {27'd0, out_val}, {27'd0, e.v});
            chk("sel", {17'd0, sel}, {17'd0, e.s});
         end
      end
   end

   initial begin
      rst      = 1'b0;
      req_dest = '0;
      out_full = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_grant", {27'd0, grant}, 32'd0);
      chk("rst_val", {27'd0, out_val}, 32'd0);
      chk("rst_sel", {17'd0, sel}, 32'd0);
      chk("rst_err", {31'd0, dest_err}, 32'd0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;

      // single request: input 0 -> output 2
      set_code(0, 3'd3);
      exp_sel[6 +: 3] = 3'd0;
      push(5'b00001, 5'b00100);
      @(posedge clk); #1;
      set_code(0, 3'd0);
      repeat (6) @(posedge clk);
      #1;

      // contention on output 0 from inputs 1, 3, 4
      set_code(1, 3'd1); set_code(3, 3'd1); set_code(4, 3'd1);
      exp_sel[0 +: 3] = 3'd1; push(5'b00010, 5'b00001);
      exp_sel[0 +: 3] = 3'd3; push(5'b01000, 5'b00001);
      exp_sel[0 +: 3] = 3'd4; push(5'b10000, 5'b00001);
      exp_sel[0 +: 3] = 3'd1; push(5'b00010, 5'b00001);
      repeat (10) @(posedge clk);
      #1;
      set_code(1, 3'd0); set_code(3, 3'd0); set_code(4, 3'd0);
      repeat (6) @(posedge clk);
      #1;

      // back-pressure on output 4
      out_full[4] = 1'b1;
      set_code(2, 3'd5);
      repeat (10) @(posedge clk);
      #1;
      chk("bp_no_val4", {31'd0, out_val[4]}, 32'd0);
      chk("bp_no_grant2", {31'd0, grant[2]}, 32'd0);
      out_full[4] = 1'b0;
      exp_sel[12 +: 3] = 3'd2;
      push(5'b00100, 5'b10000);
      @(posedge clk); #1;
      set_code(2, 3'd0);
      repeat (6) @(posedge clk);
      #1;

      // three outputs in parallel
      set_code(0, 3'd2); set_code(1, 3'd4); set_code(2, 3'd5);
      exp_sel[3 +: 3] = 3'd0; exp_sel[9 +: 3] = 3'd1; exp_sel[12 +: 3] = 3'd2;
      push(5'b00111, 5'b11010);
      @(posedge clk); #1;
      set_code(0, 3'd0); set_code(1, 3'd0); set_code(2, 3'd0);
      repeat (6) @(posedge clk);
      #1;

      // reset during XFER on output 1
      set_code(3, 3'd2);
      exp_sel[3 +: 3] = 3'd3;
      push(5'b01000, 5'b00010);
      @(posedge clk); #1;
      set_code(3, 3'd0);
      @(negedge clk); #1;
      rst = 1'b0;
      #1;
      chk("midrst_grant", {27'd0, grant}, 32'd0);
      chk("midrst_val", {27'd0, out_val}, 32'd0);
      chk("midrst_sel", {17'd0, sel}, 32'd0);
      exp_sel = '0;
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;

      // pointer back at reset value: input 3 beats input 4
      set_code(3, 3'd2); set_code(4, 3'd2);
      exp_sel[3 +: 3] = 3'd3;
      push(5'b01000, 5'b00010);
      @(posedge clk); #1;
      set_code(3, 3'd0); set_code(4, 3'd0);
      repeat (6) @(posedge clk);
      #1;

      // illegal codes
      chk("err_clear", {31'd0, dest_err}, 32'd0);
      set_code(3, 3'd7);
      @(posedge clk); #1;
      chk("err_set", {31'd0, dest_err}, 32'd1);
      set_code(3, 3'd6);
      @(posedge clk); #1;
      set_code(3, 3'd0);
      repeat (5) @(posedge clk);
      #1;
      chk("err_sticky", {31'd0, dest_err}, 32'd1);
      rst = 1'b0;
      #1;
      chk("err_reset", {31'd0, dest_err}, 32'd0);
      @(negedge clk) rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      chk("queue_drained", q.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
